// File: rtl/clock_divider_bank_pkg.sv
// -----------------------------------------------------------------------------
// clock_divider_bank_pkg
//
// Purpose:
//   Shared constants and helpers for the clock divider bank. Holds the named
//   half-period values for a 50 MHz reference clock, the default divider
//   loaded at reset, and a constant clog2 helper that sizes the channel select.
//
// Contents:
//   DIV_1HZ / DIV_2HZ / DIV_10HZ  half-periods (in reference cycles) at 50 MHz
//   DEFAULT_DIV                   half-period loaded into every channel at reset
//   clog2()                       ceiling log2, usable in constant expressions
//   sel_width()                   select width for a given channel count (min 1)
// -----------------------------------------------------------------------------
package clock_divider_bank_pkg;

    // Reference clock frequency the named constants below are derived from.
    localparam int REF_CLK_HZ = 50_000_000;

    // Half-period = REF_CLK_HZ / (2 * f_out).
    localparam int DIV_1HZ  = REF_CLK_HZ / 2;
    localparam int DIV_2HZ  = REF_CLK_HZ / 4;
    localparam int DIV_10HZ = REF_CLK_HZ / 20;

    localparam int DEFAULT_DIV = DIV_1HZ;

    // Ceiling log2; clog2(1) = 0, clog2(3) = 2, clog2(16) = 4.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A single-channel bank still needs a one-bit select port.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? clog2(channels) : 1;
    endfunction

endpackage : clock_divider_bank_pkg

// File: rtl/clock_divider_bank_if.sv
// -----------------------------------------------------------------------------
// clock_divider_bank_if
//
// Purpose:
//   Groups the control and output signals of the clock divider bank so the
//   bank and its controller connect through one port.
//
// Signals:
//   enable    [CHANNELS]   per-channel run enable, high = count
//   divLoad   [1]          strobe: write divIn into shadow[divSel]
//   divSel    [SEL_WIDTH]  channel index for divLoad
//   divIn     [CNT_WIDTH]  new half-period value (0 is ignored)
//   clockOut  [CHANNELS]   registered divided square wave per channel
//   tickOut   [CHANNELS]   one-cycle pulse with each clockOut rising edge
//
// Handshake:
//   There is no valid/ready pair here. divLoad is a single-cycle strobe that
//   is always accepted: when divLoad is high at a rising edge of clockIn,
//   divSel and divIn are sampled on that same edge. There is no backpressure.
//
// Modports:
//   master  controller side (drives enable/load, observes outputs)
//   slave   divider bank side
// -----------------------------------------------------------------------------
interface clock_divider_bank_if #(
    parameter int CHANNELS  = 3,
    parameter int CNT_WIDTH = 26
);
    import clock_divider_bank_pkg::*;

    localparam int SEL_WIDTH = sel_width(CHANNELS);

    logic [CHANNELS-1:0]  enable;
    logic                 divLoad;
    logic [SEL_WIDTH-1:0] divSel;
    logic [CNT_WIDTH-1:0] divIn;
    logic [CHANNELS-1:0]  clockOut;
    logic [CHANNELS-1:0]  tickOut;

    modport master (
        output enable,
        output divLoad,
        output divSel,
        output divIn,
        input  clockOut,
        input  tickOut
    );

    modport slave (
        input  enable,
        input  divLoad,
        input  divSel,
        input  divIn,
        output clockOut,
        output tickOut
    );

endinterface : clock_divider_bank_if

// File: rtl/clock_div_channel.sv
// -----------------------------------------------------------------------------
// clock_div_channel
//
// Purpose:
//   One divider channel. It counts reference cycles up to the active
//   half-period and toggles its output at the end of each half-period. It
//   also emits a one-cycle tick on every rising output edge. A new
//   half-period goes into a shadow register and is committed only at a
//   toggle, so the output never shows a truncated or glitched half-period.
//
// Ports:
//   clk_i   reference clock (rising edge)
//   rst_i   synchronous active-high reset
//   en_i    run enable; low freezes count, output level and active divider
//   load_i  write div_i into the shadow (the caller has already filtered
//           out zero values and out-of-range selects)
//   div_i   new half-period value N
//   clk_o   divided output, period 2*N at 50% duty
//   tick_o  high for the cycle in which clk_o has just risen
// -----------------------------------------------------------------------------
module clock_div_channel #(
    parameter int CNT_WIDTH   = 26,
    parameter int DEFAULT_DIV = 25_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] div_i,
    output logic                 clk_o,
    output logic                 tick_o
);

    localparam logic [CNT_WIDTH-1:0] DIV_RESET = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic [CNT_WIDTH-1:0] active_q, active_d;
    logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic                 clk_q,    clk_d;
    logic                 tick_q,   tick_d;

    // End of the current half-period. active_q is never zero, so
    // active_q - 1 cannot wrap. After every commit count_q <= active_q - 1,
    // so the equality compare is always reached.
    logic at_terminal;
    assign at_terminal = (count_q == (active_q - CNT_ONE));

    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        shadow_d = shadow_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;

        // The shadow accepts loads whether or not the channel is running.
        if (load_i) begin
            shadow_d = div_i;
        end

        if (en_i) begin
            if (at_terminal) begin
                count_d = '0;
                clk_d   = ~clk_q;
                // Tick only on the 0->1 transition.
                tick_d  = ~clk_q;
                // Commit point. A load landing on this same edge goes straight
                // to active instead of waiting a whole half-period in the shadow.
                active_d = load_i ? div_i : shadow_q;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            active_q <= DIV_RESET;
            shadow_q <= DIV_RESET;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule : clock_div_channel

// File: rtl/clock_divider_bank.sv
// -----------------------------------------------------------------------------
// clock_divider_bank
//
// Purpose:
//   CHANNELS independent divided square waves from one reference clock. Each
//   channel has a run-time programmable half-period, its own enable and a
//   rising-edge tick. This level decodes the shared load strobe into
//   per-channel load strobes and instantiates one clock_div_channel per
//   channel. The channels have no phase relationship to each other.
//
// Ports:
//   clockIn  reference clock; every register uses its rising edge
//   reset    synchronous active-high reset; overrides load and enable
//   bus      clock_divider_bank_if.slave:
//              enable, divLoad, divSel, divIn  (inputs)
//              clockOut, tickOut               (outputs)
//
// Parameters:
//   CHANNELS     number of channels (1..16)
//   CNT_WIDTH    counter / half-period register width
//   DEFAULT_DIV  half-period loaded at reset (1 .. 2^CNT_WIDTH-1)
// -----------------------------------------------------------------------------
module clock_divider_bank
    import clock_divider_bank_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int CNT_WIDTH   = 26,
    parameter int DEFAULT_DIV = clock_divider_bank_pkg::DEFAULT_DIV
) (
    input  logic                  clockIn,
    input  logic                  reset,
    clock_divider_bank_if.slave   bus
);

    localparam int SEL_WIDTH = sel_width(CHANNELS);

    logic                div_nonzero;
    logic [CHANNELS-1:0] load_strobe;
    logic [CHANNELS-1:0] clk_vec;
    logic [CHANNELS-1:0] tick_vec;

    // A zero half-period would break the count/terminal compare, so it is
    // dropped here and never reaches any shadow register.
    assign div_nonzero = (bus.divIn != '0);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        // An out-of-range select matches no index, so the load is dropped.
        assign load_strobe[i] = bus.divLoad && div_nonzero &&
                                (bus.divSel == SEL_WIDTH'(i));

        clock_div_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk_i  (clockIn),
            .rst_i  (reset),
            .en_i   (bus.enable[i]),
            .load_i (load_strobe[i]),
            .div_i  (bus.divIn),
            .clk_o  (clk_vec[i]),
            .tick_o (tick_vec[i])
        );
    end

    assign bus.clockOut = clk_vec;
    assign bus.tickOut  = tick_vec;

endmodule : clock_divider_bank

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;

  localparam int CH = 3;
  localparam int CW = 8;
  localparam int DD = 3;

  logic clockIn = 1'b0;
  logic reset;

  always #5 clockIn = ~clockIn;

  clock_divider_bank_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) bus ();

  clock_divider_bank #(
    .CHANNELS    (CH),
    .CNT_WIDTH   (CW),
    .DEFAULT_DIV (DD)
  ) dut (
    .clockIn (clockIn),
    .reset   (reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  // Advance one active edge and sample #1 later.
  task automatic step();
    @(posedge clockIn);
    #1;
  endtask

  task automatic drive_idle();
    bus.divLoad = 1'b0;
    bus.divSel  = '0;
    bus.divIn   = '0;
  endtask

  task automatic drive_load(input int sel, input int div);
    bus.divLoad = 1'b1;
    bus.divSel  = 2'(sel);
    bus.divIn   = 8'(div);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset      = 1'b1;
    bus.enable = 3'b111;
    drive_idle();
    step();
    step();
    checks++;
    if (bus.clockOut !== 3'b000) begin
      errors++;
      $display("FAIL reset_clk got %b exp %b", bus.clockOut, 3'b000);
    end
    checks++;
    if (bus.tickOut !== 3'b000) begin
      errors++;
      $display("FAIL reset_tick got %b exp %b", bus.tickOut, 3'b000);
    end
    reset = 1'b0;
  endtask

  // Edges 1..12 after reset release, N=3 on every channel.
  task automatic test_basic(input string name);
    int c[12];
    int t[12];
    logic [2:0] ec, et;
    c = '{0,0,1,1,1,0,0,0,1,1,1,0};
    t = '{0,0,1,0,0,0,0,0,1,0,0,0};
    for (int s = 0; s < 12; s++) begin
      drive_idle();
      step();
      ec = {3{c[s][0]}};
      et = {3{t[s][0]}};
      checks++;
      if (bus.clockOut !== ec) begin
        errors++;
        $display("FAIL %s_clk edge %0d got %b exp %b", name, s + 1, bus.clockOut, ec);
      end
      checks++;
      if (bus.tickOut !== et) begin
        errors++;
        $display("FAIL %s_tick edge %0d got %b exp %b", name, s + 1, bus.tickOut, et);
      end
    end
  endtask

  // Edges 13..27: ch1 loaded with N=1 one cycle after its rise (edge 16),
  // then with N=3 on edge 25, which coincides with a ch1 commit (bypass).
  task automatic test_load_shadow();
    int c02[15];
    int t02[15];
    int c1[15];
    int t1[15];
    logic [2:0] ec, et;
    c02 = '{0,0,1,1,1,0,0,0,1,1,1,0,0,0,1};
    t02 = '{0,0,1,0,0,0,0,0,1,0,0,0,0,0,1};
    c1  = '{0,0,1,1,1,0,1,0,1,0,1,0,1,1,1};
    t1  = '{0,0,1,0,0,0,1,0,1,0,1,0,1,0,0};
    for (int s = 0; s < 15; s++) begin
      if (s + 13 == 16)      drive_load(1, 1);
      else if (s + 13 == 25) drive_load(1, 3);
      else                   drive_idle();
      step();
      ec = {c02[s][0], c1[s][0], c02[s][0]};
      et = {t02[s][0], t1[s][0], t02[s][0]};
      checks++;
      if (bus.clockOut !== ec) begin
        errors++;
        $display("FAIL load_clk edge %0d got %b exp %b", s + 13, bus.clockOut, ec);
      end
      checks++;
      if (bus.tickOut !== et) begin
        errors++;
        $display("FAIL load_tick edge %0d got %b exp %b", s + 13, bus.tickOut, et);
      end
    end
  endtask

  // Edges 28..38: enable[0] low for edges 29..33 while ch0 is high.
  task automatic test_enable_freeze();
    int c0[11];
    int t0[11];
    int c1[11];
    int t1[11];
    int c2[11];
    int t2[11];
    logic [2:0] ec, et;
    c0 = '{1,1,1,1,1,1,1,0,0,0,1};
    t0 = '{0,0,0,0,0,0,0,0,0,0,1};
    c1 = '{0,0,0,1,1,1,0,0,0,1,1};
    t1 = '{0,0,0,1,0,0,0,0,0,1,0};
    c2 = '{1,1,0,0,0,1,1,1,0,0,0};
    t2 = '{0,0,0,0,0,1,0,0,0,0,0};
    for (int s = 0; s < 11; s++) begin
      drive_idle();
      bus.enable = (s + 28 >= 29 && s + 28 <= 33) ? 3'b110 : 3'b111;
      step();
      ec = {c2[s][0], c1[s][0], c0[s][0]};
      et = {t2[s][0], t1[s][0], t0[s][0]};
      checks++;
      if (bus.clockOut !== ec) begin
        errors++;
        $display("FAIL enable_clk edge %0d got %b exp %b", s + 28, bus.clockOut, ec);
      end
      checks++;
      if (bus.tickOut !== et) begin
        errors++;
        $display("FAIL enable_tick edge %0d got %b exp %b", s + 28, bus.tickOut, et);
      end
    end
    bus.enable = 3'b111;
  endtask

  // Edges 39..50: divIn=0 to ch2 (on a ch2 commit), then divSel=3.
  task automatic test_invalid_load();
    int c0[12];
    int t0[12];
    int c1[12];
    int t1[12];
    int c2[12];
    int t2[12];
    logic [2:0] ec, et;
    c0 = '{1,1,0,0,0,1,1,1,0,0,0,1};
    t0 = '{0,0,0,0,0,1,0,0,0,0,0,1};
    c1 = '{1,0,0,0,1,1,1,0,0,0,1,1};
    t1 = '{0,0,0,0,1,0,0,0,0,0,1,0};
    c2 = '{1,1,1,0,0,0,1,1,1,0,0,0};
    t2 = '{1,0,0,0,0,0,1,0,0,0,0,0};
    for (int s = 0; s < 12; s++) begin
      if (s + 39 == 39)      drive_load(2, 0);
      else if (s + 39 == 40) drive_load(3, 5);
      else                   drive_idle();
      step();
      ec = {c2[s][0], c1[s][0], c0[s][0]};
      et = {t2[s][0], t1[s][0], t0[s][0]};
      checks++;
      if (bus.clockOut !== ec) begin
        errors++;
        $display("FAIL invalid_clk edge %0d got %b exp %b", s + 39, bus.clockOut, ec);
      end
      checks++;
      if (bus.tickOut !== et) begin
        errors++;
        $display("FAIL invalid_tick edge %0d got %b exp %b", s + 39, bus.tickOut, et);
      end
    end
  endtask

  // Edges 51..64: load ch0 N=5 on edge 53, where count[0]==2 (commit).
  task automatic test_commit_bypass();
    int c0[14];
    int t0[14];
    int c1[14];
    int t1[14];
    int c2[14];
    int t2[14];
    logic [2:0] ec, et;
    c0 = '{1,1,0,0,0,0,0,1,1,1,1,1,0,0};
    t0 = '{0,0,0,0,0,0,0,1,0,0,0,0,0,0};
    c1 = '{1,0,0,0,1,1,1,0,0,0,1,1,1,0};
    t1 = '{0,0,0,0,1,0,0,0,0,0,1,0,0,0};
    c2 = '{1,1,1,0,0,0,1,1,1,0,0,0,1,1};
    t2 = '{1,0,0,0,0,0,1,0,0,0,0,0,1,0};
    for (int s = 0; s < 14; s++) begin
      if (s + 51 == 53) drive_load(0, 5);
      else              drive_idle();
      step();
      ec = {c2[s][0], c1[s][0], c0[s][0]};
      et = {t2[s][0], t1[s][0], t0[s][0]};
      checks++;
      if (bus.clockOut !== ec) begin
        errors++;
        $display("FAIL bypass_clk edge %0d got %b exp %b", s + 51, bus.clockOut, ec);
      end
      checks++;
      if (bus.tickOut !== et) begin
        errors++;
        $display("FAIL bypass_tick edge %0d got %b exp %b", s + 51, bus.tickOut, et);
      end
    end
  endtask

  // Edge 65 loads ch2 N=5 into the shadow; edge 66 is a one-cycle reset
  // while ch2 is high. Afterwards every channel runs at N=3 again.
  task automatic test_reset_mid();
    drive_load(2, 5);
    step();
    checks++;
    if (bus.clockOut !== 3'b100) begin
      errors++;
      $display("FAIL pre_reset_clk got %b exp %b", bus.clockOut, 3'b100);
    end
    drive_idle();
    reset = 1'b1;
    step();
    checks++;
    if (bus.clockOut !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_clk got %b exp %b", bus.clockOut, 3'b000);
    end
    checks++;
    if (bus.tickOut !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_tick got %b exp %b", bus.tickOut, 3'b000);
    end
    reset = 1'b0;
    test_basic("after_reset");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset       = 1'b1;
    bus.enable  = 3'b111;
    bus.divLoad = 1'b0;
    bus.divSel  = '0;
    bus.divIn   = '0;

    test_reset();
    test_basic("basic");
    test_load_shadow();
    test_enable_freeze();
    test_invalid_load();
    test_commit_bypass();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_clock_divider_bank
